keypad_event_controller: RTL

//  Sequences the keypad scanner and turns its held key code into discrete key-press events.
//  - Generates the scan strobe.
//  - Debounces the code.
//  - Emits exactly one event per press, held in a small FIFO.
//  - Consumer drains the FIFO with a valid/ready handshake.

---
 rtl/keypad_event_controller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_event_controller.sv
// keypad_event_controller
//   Scan-strobe prescaler, key-code debouncer and a small first-word-fall-through
//   event FIFO drained by a valid/ready consumer. Code 4'h0 means "no key".
//   Optional auto-repeat of a held key is built only when AUTO_REPEAT_EN is defined.
//
// FSM states:
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ST_IDLE     | no key held, waiting for a nonzero code
//   ST_DEBOUNCE | candidate code seen, counting identical samples
//   ST_PRESSED  | press accepted and event pushed, waiting for release/rollover
//   ST_RELEASE  | zero seen after a press, counting zero samples
module keypad_event_controller #(
  parameter int PRESCALE_DIV = 1000,
  parameter int STABLE_TICKS = 24,
  parameter int FIFO_DEPTH   = 8
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 60
`endif
) (
  input  logic       clock,
  input  logic       resetN,
  output logic       scanTick,
  input  logic [3:0] keyCode,
  output logic [3:0] eventData,
  output logic       eventValid,
  input  logic       eventReady,
  output logic [4:0] fifoCount,
  output logic       overflow,
  input  logic       clearOverflow
);

  localparam int PW = $clog2(PRESCALE_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  // A single stable sample is enough: every fresh code is accepted on sight.
  localparam bit INSTANT = (STABLE_TICKS == 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

  logic [PW-1:0] presc_cnt;
  state_t        state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic          new_code;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW-1:0] wr_ptr;
  logic [3:0]    mem [FIFO_DEPTH];

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rep_tmr;
  logic          rep_tc;
  assign rep_tc = (rep_tmr == RW'(1));
`endif

  // Prescaler; scanTick is registered so it is high exactly while the count sits at DIV-1.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      presc_cnt <= '0;
      scanTick  <= 1'b0;
    end else begin
      if (presc_cnt == PW'(PRESCALE_DIV - 1)) presc_cnt <= '0;
      else                                    presc_cnt <= presc_cnt + 1'b1;
      scanTick <= (presc_cnt == PW'(PRESCALE_DIV - 2));
    end
  end

  assign new_code = (keyCode != 4'h0) && (keyCode != cand);

  // Push decode; the pushed code always equals the sampled keyCode.
  always_comb begin
    push = 1'b0;
    if (scanTick) begin
      case (state)
        ST_IDLE:     push = INSTANT && (keyCode != 4'h0);
        ST_DEBOUNCE: push = (keyCode == cand) ? (cnt == CW'(STABLE_TICKS - 1)) : (INSTANT && new_code);
`ifdef AUTO_REPEAT_EN
        ST_PRESSED:  push = (INSTANT && new_code) || ((keyCode == cand) && rep_tc);
`else
        ST_PRESSED:  push = INSTANT && new_code;
`endif
        ST_RELEASE:  push = INSTANT && new_code;
        default:     push = 1'b0;
      endcase
    end
  end

  // Debounce FSM, advanced only on scan ticks.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state <= ST_IDLE;
      cand  <= 4'h0;
      cnt   <= '0;
    end else if (scanTick) begin
      case (state)
        ST_IDLE: begin
          if (keyCode != 4'h0) begin
            cand  <= keyCode;
            cnt   <= CW'(1);
            state <= INSTANT ? ST_PRESSED : ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (keyCode == cand) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(STABLE_TICKS - 1)) state <= ST_PRESSED;
          end else if (keyCode == 4'h0) begin
            state <= ST_IDLE;
          end else begin
            cand  <= keyCode;
            cnt   <= CW'(1);
            state <= INSTANT ? ST_PRESSED : ST_DEBOUNCE;
          end
        end
        ST_PRESSED: begin
          if (keyCode == 4'h0) begin
            cnt   <= CW'(1);
            state <= INSTANT ? ST_IDLE : ST_RELEASE;
          end else if (keyCode != cand) begin
            cand  <= keyCode;
            cnt   <= CW'(1);
            state <= INSTANT ? ST_PRESSED : ST_DEBOUNCE;
          end
        end
        ST_RELEASE: begin
          if (keyCode == 4'h0) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(STABLE_TICKS - 1)) state <= ST_IDLE;
          end else if (keyCode == cand) begin
            state <= ST_PRESSED;
          end else begin
            cand  <= keyCode;
            cnt   <= CW'(1);
            state <= INSTANT ? ST_PRESSED : ST_DEBOUNCE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  // Repeat down-counter: reloads with the initial delay whenever the key is not being held in PRESSED.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      rep_tmr <= RW'(REPEAT_DELAY);
    end else if (scanTick) begin
      if ((state == ST_PRESSED) && (keyCode == cand)) rep_tmr <= rep_tc ? RW'(REPEAT_RATE) : rep_tmr - 1'b1;
      else                                            rep_tmr <= RW'(REPEAT_DELAY);
    end
  end
`endif

  assign eventValid = (fifoCount != 5'd0);
  assign pop        = eventValid && eventReady;
  assign full       = (fifoCount == 5'(FIFO_DEPTH));
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign rd_next    = rd_ptr + 1'b1;

  // Event storage; no reset needed, contents are qualified by fifoCount.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= keyCode;
  end

  // FIFO pointers, count, registered head and sticky overflow.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifoCount <= 5'd0;
      overflow  <= 1'b0;
      eventData <= 4'h0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_next;
      case ({push_ok, pop})
        2'b10:   fifoCount <= fifoCount + 5'd1;
        2'b01:   fifoCount <= fifoCount - 5'd1;
        default: fifoCount <= fifoCount;
      endcase
      if (drop)               overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
      // Head follows the oldest entry; it holds its last value once the FIFO drains.
      if (fifoCount == 5'd0) begin
        if (push_ok) eventData <= keyCode;
      end else if (pop) begin
        if (fifoCount == 5'd1) begin
          if (push_ok) eventData <= keyCode;
        end else begin
          eventData <= mem[rd_next];
        end
      end
    end
  end

endmodule
